// File: rtl/sample_sequencer.sv
// Periodic multi-channel sampler: a tick timer starts a round that walks the enabled
// channels in ascending order, capturing each onto one valid/ready output.
module sample_sequencer #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         period,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     ovr_clr,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          ch_sel,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    output logic                     round_done,
    output logic [7:0]               round_cnt,
    output logic                     overrun,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, SEL, CAP, VALID} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]   round_mask_q, round_mask_d;
    logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;
    logic                out_valid_q, out_valid_d;
    logic                round_done_q, round_done_d;
    logic [7:0]          round_cnt_q, round_cnt_d;
    logic                overrun_q, overrun_d;
    logic [DIV_W-1:0]    per_m1;
    logic                tick;
    logic [CH_W:0]       first_hit, next_hit;

    // Returns {found, index} of the lowest set bit of m at or above start.
    function automatic logic [CH_W:0] find_from(input logic [NUM_CH-1:0] m, input int start);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (i >= start)) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    // A shrunken period fires on the next compare instead of waiting for a 16-bit wrap.
    assign per_m1    = (period == '0) ? '0 : period - DIV_W'(1);
    assign tick      = enable && (cnt_q >= per_m1);
    assign first_hit = find_from(ch_mask, 0);
    assign next_hit  = find_from(round_mask_q, int'(ch_sel_q) + 1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + DIV_W'(1);
        round_mask_d = round_mask_q;
        ch_sel_d     = ch_sel_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_valid_d  = out_valid_q;
        round_done_d = 1'b0;
        round_cnt_d  = round_cnt_q;
        overrun_d    = overrun_q;

        if (!enable || tick) cnt_d = '0;

        if (tick && (state_q != IDLE)) overrun_d = 1'b1;
        else if (ovr_clr)              overrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick && (ch_mask != '0)) begin
                    round_mask_d = ch_mask;
                    ch_sel_d     = first_hit[CH_W-1:0];
                    state_d      = SEL;
                end
            end
            SEL: state_d = CAP;
            CAP: begin
                out_data_d  = ch_data[int'(ch_sel_q)*DATA_W +: DATA_W];
                out_ch_d    = ch_sel_q;
                out_valid_d = 1'b1;
                state_d     = VALID;
            end
            VALID: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (next_hit[CH_W]) begin
                        ch_sel_d = next_hit[CH_W-1:0];
                        state_d  = SEL;
                    end else begin
                        round_done_d = 1'b1;
                        round_cnt_d  = round_cnt_q + 8'd1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            round_mask_q <= '0;
            ch_sel_q     <= '0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
            round_done_q <= 1'b0;
            round_cnt_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            round_mask_q <= round_mask_d;
            ch_sel_q     <= ch_sel_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
            round_done_q <= round_done_d;
            round_cnt_q  <= round_cnt_d;
            overrun_q    <= overrun_d;
        end
    end

    assign ch_sel     = ch_sel_q;
    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign out_valid  = out_valid_q;
    assign round_done = round_done_q;
    assign round_cnt  = round_cnt_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: directed scenarios plus random traffic, every cycle
// compared against a queue-based round model.
module tb_sample_sequencer;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     enable = 1'b0;
    logic [DIV_W-1:0]         period = '0;
    logic [NUM_CH-1:0]        ch_mask = '0;
    logic [NUM_CH*DATA_W-1:0] ch_data = '0;
    logic                     ovr_clr = 1'b0;
    logic                     out_ready = 1'b0;
    logic [CH_W-1:0]          ch_sel;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_valid;
    logic                     round_done;
    logic [7:0]               round_cnt;
    logic                     overrun;
    logic                     busy;

    sample_sequencer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .ch_mask(ch_mask),
        .ch_data(ch_data), .ovr_clr(ovr_clr), .out_ready(out_ready), .ch_sel(ch_sel),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .round_done(round_done),
        .round_cnt(round_cnt), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a round is a queue of channels still to be delivered;
    // m_gap counts the settle/capture cycles before the head channel becomes valid.
    int         m_cnt;
    int         m_q[$];
    int         m_gap;
    logic [7:0] m_data;
    int         m_ch;
    bit         m_valid;
    bit         m_done;
    logic [7:0] m_rcnt;
    bit         m_ovr;
    int         m_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_q.delete(); m_gap = 0; m_data = '0; m_ch = 0;
        m_valid = 0; m_done = 0; m_rcnt = '0; m_ovr = 0; m_sel = 0;
    endtask

    task automatic model_edge();
        int p;
        bit tk, in_round;
        p        = (period == 0) ? 1 : int'(period);
        in_round = (m_q.size() > 0);
        tk       = enable && (m_cnt >= p - 1);
        m_cnt    = (!enable || tk) ? 0 : m_cnt + 1;
        m_done   = 0;
        if (tk && in_round) m_ovr = 1;
        else if (ovr_clr)   m_ovr = 0;
        if (!in_round) begin
            if (tk && ch_mask != 0) begin
                for (int i = 0; i < NUM_CH; i++) if (ch_mask[i]) m_q.push_back(i);
                m_sel = m_q[0];
                m_gap = 2;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) begin
                m_valid = 1;
                m_ch    = m_q[0];
                m_data  = ch_data[m_q[0]*DATA_W +: DATA_W];
            end
        end else if (out_ready) begin
            m_valid = 0;
            void'(m_q.pop_front());
            if (m_q.size() > 0) begin
                m_sel = m_q[0];
                m_gap = 2;
            end else begin
                m_done = 1;
                m_rcnt = m_rcnt + 8'd1;
            end
        end
    endtask

    task automatic check_outs();
        chk("ch_sel",     ch_sel,     m_sel);
        chk("out_data",   out_data,   m_data);
        chk("out_ch",     out_ch,     m_ch);
        chk("out_valid",  out_valid,  m_valid);
        chk("round_done", round_done, m_done);
        chk("round_cnt",  round_cnt,  m_rcnt);
        chk("overrun",    overrun,    m_ovr);
        chk("busy",       busy,       m_q.size() > 0);
    endtask

    // Called from a negedge; returns at the following negedge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_edge();
            #1;
            check_outs();
            @(negedge clk);
        end
    endtask

    task automatic drain();
        enable = 0; out_ready = 1; ovr_clr = 0;
        step(20);
    endtask

    task automatic wait_busy(input string tag);
        int k;
        k = 0;
        while (!busy && k < 200) begin step(1); k++; end
        chk(tag, busy, 1'b1);
    endtask

    initial begin
        int nv, t_busy, t_valid, rc0, nrounds, k;
        int seen_ch[$];
        logic [7:0] seen_d[$];
        model_reset();

        // Reset holds every output low regardless of inputs
        rst_n = 0; enable = 1; period = 16'd1; ch_mask = 4'hF; ch_data = $urandom;
        out_ready = 1; ovr_clr = 0;
        @(negedge clk);
        step(4);
        rst_n = 1; enable = 0;
        step(50);

        // Basic round
        period = 16'd10; ch_mask = 4'hF; ch_data = 32'h44332211; out_ready = 1; enable = 1;
        t_busy = -1; t_valid = -1;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (busy && t_busy < 0) t_busy = c;
            if (out_valid && t_valid < 0) t_valid = c;
            if (out_valid && seen_d.size() < 4) begin seen_d.push_back(out_data); seen_ch.push_back(int'(out_ch)); end
        end
        chk("basic.latency", t_valid - t_busy, 2);
        chk("basic.count", seen_d.size(), 4);
        for (int i = 0; i < 4 && i < seen_d.size(); i++) begin
            chk("basic.data", seen_d[i], 8'h11 * (i + 1));
            chk("basic.ch", seen_ch[i], i);
        end
        drain();

        // Sparse mask with backpressure
        period = 16'd50; ch_mask = 4'b1010; out_ready = 0; enable = 1; ch_data = 32'hD4C3B2A1;
        k = 0;
        while (!out_valid && k < 100) begin step(1); k++; end
        chk("sparse.first_valid", out_valid, 1'b1);
        enable = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("sparse.hold_ch", out_ch, 1);
            chk("sparse.hold_data", out_data, 8'hB2);
        end
        out_ready = 1;
        seen_ch.delete();
        for (int c = 0; c < 12; c++) begin
            if (out_valid) seen_ch.push_back(int'(out_ch));
            step(1);
        end
        chk("sparse.n", seen_ch.size(), 2);
        if (seen_ch.size() == 2) begin
            chk("sparse.ch0", seen_ch[0], 1);
            chk("sparse.ch1", seen_ch[1], 3);
        end
        drain();

        // Overrun: ticks during a stalled round
        period = 16'd2; ch_mask = 4'hF; out_ready = 0; enable = 1;
        rc0 = int'(round_cnt);
        step(6);
        chk("ovr.set", overrun, 1'b1);
        k = 0;
        while (m_cnt < 1 && k < 10) begin step(1); k++; end
        ovr_clr = 1;
        step(1);
        ovr_clr = 0;
        chk("ovr.set_wins", overrun, 1'b1);
        chk("ovr.no_round", round_cnt, rc0);
        drain();
        ovr_clr = 1;
        step(1);
        ovr_clr = 0;
        chk("ovr.clr", overrun, 1'b0);

        // Empty mask: ticks do nothing
        period = 16'd3; ch_mask = 4'h0; enable = 1; nv = 0;
        for (int c = 0; c < 30; c++) begin step(1); nv += int'(out_valid) + int'(round_done) + int'(overrun); end
        chk("mask0.activity", nv, 0);
        drain();

        // Mask change mid-round has no effect on that round
        period = 16'd20; ch_mask = 4'hF; enable = 1; out_ready = 1;
        wait_busy("maskchg.start");
        ch_mask = 4'h1; nv = 0;
        for (int c = 0; c < 14; c++) begin step(1); nv += int'(out_valid); end
        chk("maskchg.n", nv, 4);
        drain();

        // Enable dropped mid-round: round completes, no new round
        period = 16'd6; ch_mask = 4'hF; enable = 1; out_ready = 1;
        wait_busy("endrop.start");
        enable = 0; nv = 0;
        for (int c = 0; c < 30; c++) begin step(1); nv += int'(out_valid); end
        chk("endrop.n", nv, 4);
        chk("endrop.idle", busy, 1'b0);
        drain();

        // 256 back-to-back rounds wrap round_cnt
        period = 16'd4; ch_mask = 4'h1; enable = 1; out_ready = 1;
        rc0 = int'(round_cnt); nrounds = 0; k = 0;
        while (nrounds < 256 && k < 2000) begin
            step(1);
            if (round_done) nrounds++;
            k++;
        end
        chk("wrap.rounds", nrounds, 256);
        chk("wrap.cnt", round_cnt, rc0);
        drain();

        // Random traffic
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 40) == 0) period = 16'($urandom_range(0, 20));
            if ($urandom_range(0, 10) == 0) ch_mask = 4'($urandom);
            ch_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            ovr_clr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 30) == 0) enable = ~enable;
            step(1);
        end
        drain();

        // Asynchronous reset while a sample is waiting
        period = 16'd5; ch_mask = 4'hF; enable = 1; out_ready = 0;
        k = 0;
        while (!out_valid && k < 50) begin step(1); k++; end
        chk("arst.reach_valid", out_valid, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("arst.valid_drop", out_valid, 1'b0);
        chk("arst.busy_drop", busy, 1'b0);
        model_reset();
        @(negedge clk);
        step(2);
        rst_n = 1; enable = 0; out_ready = 1;
        nv = 0;
        for (int c = 0; c < 10; c++) begin step(1); nv += int'(round_done); end
        chk("arst.no_done", nv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
